multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle main controller's one-shot decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives the PC, IR, register-file and memory strobes over one shared, wait-stated memory port. It also flags illegal instructions and memory timeouts, and on either it halts the core.

Parameters:
MEM_TIMEOUT, 16, consecutive cycles with mem_ready low (in FETCH or MEM) before the FSM halts with mem_timeout.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
run  in  1  enable; sampled in IDLE and at instruction retire
op_code  in  7  IR[6:0], valid from DECODE onward
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
branch_taken  in  1  comparator result from datapath, valid in EXEC
mem_ready  in  1  memory port completes the current access this cycle
ir_wr  out  1  load IR from read data
pc_wr  out  1  update PC
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 rs1+imm
addr_sel  out  1  0 memory address = PC, 1 = ALU result
reg_wr  out  1  register-file write enable
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem2reg  out  1  writeback source is memory data
alu_ctrl  out  4  ALU operation code
alu_src_sel  out  1  ALU operand B: 0 = rs2, 1 = imm
instr_retired  out  1  one-cycle pulse per completed instruction
illegal_op  out  1  sticky; set on illegal decode
mem_timeout  out  1  sticky; set on memory timeout
halted  out  1  high in HALT
state  out  3  current state, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unreachable and recovers to IDLE.
- Reset (rst_n low at an edge):
  - state goes to IDLE; sticky flags and the wait counter clear.
  - While rst_n is low, every strobe output is forced to 0: ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, instr_retired.
  - Reset mid-access abandons the instruction; no partial write occurs.
- IDLE: all outputs 0. run=1 moves to FETCH.
- FETCH: mem_rd=1, addr_sel=0.
  - mem_ready=1: ir_wr=1 in the same cycle, then DECODE.
  - mem_ready=0: remain in FETCH and increment the wait counter.
- DECODE: op_code/func3/func7 are latched into an internal class/alu_ctrl register. Illegal instruction goes to HALT with illegal_op=1; otherwise EXEC.
- Illegal instruction is any of:
  - an opcode outside {LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111};
  - OP with func7 not 00/20, or func7=20 with func3 not 000/101;
  - OP-IMM func3=001 with func7≠00, or func3=101 with func7 not 00/20.
- alu_ctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- alu_ctrl is ADD for LOAD/STORE/JAL/JALR/LUI/AUIPC and SUB for BRANCH. alu_ctrl and alu_src_sel are held constant from EXEC through WB.
- EXEC:
  - BRANCH: pc_wr=1; pc_sel=01 if branch_taken, else 00; retire.
  - JAL: reg_wr=1 (link), pc_wr=1, pc_sel=01; retire.
  - JALR: as JAL but pc_sel=10, alu_src_sel=1.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM: addr_sel=1, alu_src_sel=1; mem_rd (LOAD) or mem_wr (STORE) is held until mem_ready.
  - On mem_ready, STORE: pc_wr=1, pc_sel=00; retire.
  - On mem_ready, LOAD: go to WB.
- WB: reg_wr=1, mem2reg=(class==LOAD), pc_wr=1, pc_sel=00; retire.
- Retire: instr_retired=1 for exactly one cycle. Next state is FETCH if run=1, else IDLE. Deasserting run mid-instruction lets that instruction complete.
- Wait counter:
  - Width clog2(MEM_TIMEOUT+1). Cleared on entry to FETCH or MEM.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready=0, the next state is HALT and mem_timeout is set.
  - mem_ready=1 in that same cycle wins: normal completion, no timeout.
- HALT: all strobes 0, halted=1. Only reset exits.
- Latency with mem_ready tied high:
  - OP/OP-IMM/LUI/AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JAL/JALR: 3 cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - alu_ctrl constants;
  - instruction-class enum (LOAD, STORE, OP, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC).
- One sub-module, instr_class_decoder: combinational {op_code, func3, func7} → {class, alu_ctrl, illegal}. The FSM registers its outputs in DECODE.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), run=1, mem_ready=1 → states 1,2,3,5,1; WB cycle shows reg_wr=1, alu_ctrl=0000, pc_sel=00; instr_retired pulses once 4 cycles after FETCH entry.
- LW (0x0000A183) with mem_ready low 3 cycles in MEM → mem_rd held 4 cycles with addr_sel=1; WB shows mem2reg=1; 8 cycles total.
- BEQ: branch_taken=1 → pc_sel=01, pc_wr=1 in EXEC; branch_taken=0 → pc_sel=00; neither writes a register; 3 cycles.
- Opcode 0x7F, then SUB-like func7=0x20 with func3=001 → HALT, illegal_op=1, no reg_wr/mem_wr; remains halted until rst_n low for one edge.
- mem_ready held low in FETCH → halted after exactly 16 cycles with mem_timeout=1. Rerun with mem_ready rising on cycle 16 → normal DECODE, no timeout.
- rst_n low during MEM of SW → mem_wr=0 that cycle, state=IDLE next cycle. Also: run dropped during EXEC → instruction retires, then IDLE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_LOAD   = 4'd0,
    CL_STORE  = 4'd1,
    CL_OP     = 4'd2,
    CL_OPIMM  = 4'd3,
    CL_BRANCH = 4'd4,
    CL_JAL    = 4'd5,
    CL_JALR   = 4'd6,
    CL_LUI    = 4'd7,
    CL_AUIPC  = 4'd8
  } class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    class_e     cls;
    logic [3:0] alu;
    logic       alu_src;
    logic       illegal;
  } dec_s;

  // func3 -> ALU op; alt selects SUB/SRA variants.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000: r = alt ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational decode of opcode/func fields into class, ALU op and legality.
module instr_class_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op_code,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output dec_s       o_dec
);

  logic w_f7_zero;
  logic w_f7_alt;

  assign w_f7_zero = (i_func7 == 7'h00);
  assign w_f7_alt  = (i_func7 == 7'h20);

  always_comb begin
    o_dec.cls     = CL_LOAD;
    o_dec.alu     = ALU_ADD;
    o_dec.alu_src = 1'b1;
    o_dec.illegal = 1'b0;
    case (i_op_code)
      OPC_LOAD:  o_dec.cls = CL_LOAD;
      OPC_STORE: o_dec.cls = CL_STORE;
      OPC_OP: begin
        o_dec.cls     = CL_OP;
        o_dec.alu_src = 1'b0;
        o_dec.alu     = alu_from_f3(i_func3, w_f7_alt);
        o_dec.illegal = !(w_f7_zero || w_f7_alt) ||
                        (w_f7_alt && (i_func3 != 3'b000) && (i_func3 != 3'b101));
      end
      OPC_OPIMM: begin
        // func7 is immediate bits except for the shift encodings
        o_dec.cls     = CL_OPIMM;
        o_dec.alu     = alu_from_f3(i_func3, (i_func3 == 3'b101) && w_f7_alt);
        o_dec.illegal = ((i_func3 == 3'b001) && !w_f7_zero) ||
                        ((i_func3 == 3'b101) && !(w_f7_zero || w_f7_alt));
      end
      OPC_BRANCH: begin
        o_dec.cls     = CL_BRANCH;
        o_dec.alu     = ALU_SUB;
        o_dec.alu_src = 1'b0;
      end
      OPC_JAL:   o_dec.cls = CL_JAL;
      OPC_JALR:  o_dec.cls = CL_JALR;
      OPC_LUI:   o_dec.cls = CL_LUI;
      OPC_AUIPC: o_dec.cls = CL_AUIPC;
      default:   o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer driving PC, IR, regfile and a shared wait-stated memory port.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pc_sel,
  output logic       addr_sel,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem2reg,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_sel,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic       halted,
  output logic [2:0] state
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_next;
  state_e            w_retire_st;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              r_timeout;
  class_e            r_cls;
  logic [3:0]        r_alu;
  logic              r_alu_src;
  dec_s              w_dec;
  logic              w_wait_inc;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_latch;

  instr_class_decoder u_dec (
    .i_op_code (op_code),
    .i_func3   (func3),
    .i_func7   (func7),
    .o_dec     (w_dec)
  );

  // State, wait counter, sticky flags and latched decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_cls     <= CL_LOAD;
      r_alu     <= ALU_ADD;
      r_alu_src <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_inc ? (r_wait + WAIT_W'(1)) : '0;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
      if (w_latch) begin
        r_cls     <= w_dec.cls;
        r_alu     <= w_dec.alu;
        r_alu_src <= w_dec.alu_src;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_retire_st   = run ? ST_FETCH : ST_IDLE;
    w_wait_inc    = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_latch       = 1'b0;
    ir_wr         = 1'b0;
    pc_wr         = 1'b0;
    pc_sel        = 2'b00;
    addr_sel      = 1'b0;
    reg_wr        = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem2reg       = 1'b0;
    alu_ctrl      = ALU_ADD;
    alu_src_sel   = 1'b0;
    instr_retired = 1'b0;
    halted        = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_FETCH;
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr  = 1'b1;
          w_next = ST_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_next        = ST_HALT;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        w_latch = 1'b1;
        if (w_dec.illegal) begin
          w_next        = ST_HALT;
          w_set_illegal = 1'b1;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_ctrl    = r_alu;
        alu_src_sel = r_alu_src;
        case (r_cls)
          CL_BRANCH: begin
            pc_wr         = 1'b1;
            pc_sel        = branch_taken ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
            w_next        = w_retire_st;
          end
          CL_JAL, CL_JALR: begin
            reg_wr        = 1'b1;
            pc_wr         = 1'b1;
            pc_sel        = (r_cls == CL_JALR) ? 2'b10 : 2'b01;
            instr_retired = 1'b1;
            w_next        = w_retire_st;
          end
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          default:           w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_ctrl    = r_alu;
        alu_src_sel = 1'b1;
        addr_sel    = 1'b1;
        mem_rd      = (r_cls == CL_LOAD);
        mem_wr      = (r_cls == CL_STORE);
        if (mem_ready) begin
          if (r_cls == CL_STORE) begin
            pc_wr         = 1'b1;
            instr_retired = 1'b1;
            w_next        = w_retire_st;
          end else begin
            w_next = ST_WB;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next        = ST_HALT;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        alu_ctrl      = r_alu;
        alu_src_sel   = r_alu_src;
        reg_wr        = 1'b1;
        mem2reg       = (r_cls == CL_LOAD);
        pc_wr         = 1'b1;
        instr_retired = 1'b1;
        w_next        = w_retire_st;
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
    // Strobes are suppressed for the whole reset cycle so no partial access escapes.
    if (!rst_n) begin
      ir_wr         = 1'b0;
      pc_wr         = 1'b0;
      reg_wr        = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign illegal_op  = r_illegal;
  assign mem_timeout = r_timeout;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for the multi-cycle control sequencer.
module tb_multicycle_ctrl_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] op_code;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       branch_taken;
  logic       mem_ready;
  logic       ir_wr, pc_wr, addr_sel, reg_wr, mem_rd, mem_wr, mem2reg;
  logic [1:0] pc_sel;
  logic [3:0] alu_ctrl;
  logic       alu_src_sel, instr_retired, illegal_op, mem_timeout, halted;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [3:0] alu;
    logic       rw;
    logic       m2r;
    logic [1:0] psel;
    logic       src;
    bit         chk_src;
    int         cycles;
    int         memc;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op_code(op_code), .func3(func3),
    .func7(func7), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem2reg(mem2reg),
    .alu_ctrl(alu_ctrl), .alu_src_sel(alu_src_sel), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [3:0] a, input logic rw,
                              input logic m2r, input logic [1:0] ps, input logic src,
                              input bit cs, input int cyc, input int mc);
    exp_t e;
    e.name = n; e.alu = a; e.rw = rw; e.m2r = m2r; e.psel = ps;
    e.src = src; e.chk_src = cs; e.cycles = cyc; e.memc = mc;
    return e;
  endfunction

  // Run one instruction from its FETCH cycle to retire; compare against the popped expectation.
  task automatic do_instr(input logic [31:0] ir, input logic br, input int fwaits,
                          input int mwaits, input bit drop_run, input exp_t e);
    int cyc, memc, fw, mw;
    bit done;
    exp_t x;
    cyc = 0; memc = 0; fw = 0; mw = 0; done = 0;
    sb.push_back(e);
    op_code = ir[6:0]; func3 = ir[14:12]; func7 = ir[31:25]; branch_taken = br;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (state == ST_FETCH) begin
        mem_ready = (fw >= fwaits); fw++;
      end else if (state == ST_MEM) begin
        mem_ready = (mw >= mwaits); mw++;
      end else begin
        mem_ready = 1'b1;
      end
      if (drop_run && state == ST_EXEC) run = 1'b0;
      #1;
      if (cyc > 0 || state == ST_FETCH) begin
        cyc++;
        if (state == ST_MEM && (mem_rd || mem_wr) && addr_sel) memc++;
        if (instr_retired) begin
          x = sb.pop_front();
          done = 1;
          check({x.name, ":cycles"},  32'(cyc),      32'(x.cycles));
          check({x.name, ":alu"},     32'(alu_ctrl), 32'(x.alu));
          check({x.name, ":reg_wr"},  32'(reg_wr),   32'(x.rw));
          check({x.name, ":mem2reg"}, 32'(mem2reg),  32'(x.m2r));
          check({x.name, ":pc_sel"},  32'(pc_sel),   32'(x.psel));
          check({x.name, ":pc_wr"},   32'(pc_wr),    32'd1);
          check({x.name, ":memcyc"},  32'(memc),     32'(x.memc));
          if (x.chk_src) check({x.name, ":src"}, 32'(alu_src_sel), 32'(x.src));
        end
      end
    end
    check({e.name, ":retired"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst:strobes", 32'({ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, instr_retired}), 32'd0);
    @(negedge clk);
    #1;
    check("rst:state",   32'(state),       32'(ST_IDLE));
    check("rst:flags",   32'({illegal_op, mem_timeout, halted}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic do_illegal(input string name, input logic [31:0] ir);
    int cyc;
    bit bad, seen;
    cyc = 0; bad = 0; seen = 0;
    op_code = ir[6:0]; func3 = ir[14:12]; func7 = ir[31:25];
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (cyc > 0 || state == ST_FETCH) begin
        cyc++;
        if (reg_wr || mem_wr) bad = 1;
        if (halted) seen = 1;
      end
    end
    check({name, ":halted"},  32'(seen),        32'd1);
    check({name, ":cycles"},  32'(cyc),         32'd3);
    check({name, ":illegal"}, 32'(illegal_op),  32'd1);
    check({name, ":timeout"}, 32'(mem_timeout), 32'd0);
    check({name, ":nowrite"}, 32'(bad),         32'd0);
    repeat (3) @(negedge clk);
    #1;
    check({name, ":stays"},   32'(state),       32'(ST_HALT));
    do_reset();
  endtask

  initial begin
    int fc;
    bit seen, hit;
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    op_code = '0; func3 = '0; func7 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset:state",   32'(state), 32'(ST_IDLE));
    check("reset:strobes", 32'({ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, instr_retired}), 32'd0);
    check("reset:flags",   32'({illegal_op, mem_timeout, halted}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle:hold", 32'(state), 32'(ST_IDLE));
    run = 1'b1;

    do_instr(32'h002081B3, 1'b0, 0, 0, 0, mk("add",   ALU_ADD,  1, 0, 2'b00, 0, 1, 4, 0));
    do_instr(32'h402081B3, 1'b0, 0, 0, 0, mk("sub",   ALU_SUB,  1, 0, 2'b00, 0, 1, 4, 0));
    do_instr(32'h4020D1B3, 1'b0, 0, 0, 0, mk("sra",   ALU_SRA,  1, 0, 2'b00, 0, 1, 4, 0));
    do_instr(32'h0020E1B3, 1'b0, 0, 0, 0, mk("or",    ALU_OR,   1, 0, 2'b00, 0, 1, 4, 0));
    do_instr(32'h00508193, 1'b0, 0, 0, 0, mk("addi",  ALU_ADD,  1, 0, 2'b00, 1, 1, 4, 0));
    do_instr(32'h0050B193, 1'b0, 0, 0, 0, mk("sltiu", ALU_SLTU, 1, 0, 2'b00, 1, 1, 4, 0));
    do_instr(32'h4050D193, 1'b0, 0, 0, 0, mk("srai",  ALU_SRA,  1, 0, 2'b00, 1, 1, 4, 0));
    do_instr(32'h123451B7, 1'b0, 0, 0, 0, mk("lui",   ALU_ADD,  1, 0, 2'b00, 0, 0, 4, 0));
    do_instr(32'h00001197, 1'b0, 0, 0, 0, mk("auipc", ALU_ADD,  1, 0, 2'b00, 0, 0, 4, 0));
    do_instr(32'h0000A183, 1'b0, 0, 3, 0, mk("lw",    ALU_ADD,  1, 1, 2'b00, 1, 1, 8, 4));
    do_instr(32'h0000A183, 1'b0, 0, 0, 0, mk("lw0",   ALU_ADD,  1, 1, 2'b00, 1, 1, 5, 1));
    do_instr(32'h0030A023, 1'b0, 0, 0, 0, mk("sw",    ALU_ADD,  0, 0, 2'b00, 1, 1, 4, 1));
    do_instr(32'h00208463, 1'b1, 0, 0, 0, mk("beq_t", ALU_SUB,  0, 0, 2'b01, 0, 0, 3, 0));
    do_instr(32'h00208463, 1'b0, 0, 0, 0, mk("beq_n", ALU_SUB,  0, 0, 2'b00, 0, 0, 3, 0));
    do_instr(32'h008000EF, 1'b0, 0, 0, 0, mk("jal",   ALU_ADD,  1, 0, 2'b01, 0, 0, 3, 0));
    do_instr(32'h000080E7, 1'b0, 0, 0, 0, mk("jalr",  ALU_ADD,  1, 0, 2'b10, 1, 1, 3, 0));
    // Ready arrives on the last allowed fetch cycle: completes without timeout.
    do_instr(32'h002081B3, 1'b0, 15, 0, 0, mk("add_w15", ALU_ADD, 1, 0, 2'b00, 0, 1, 19, 0));
    check("w15:no_timeout", 32'(mem_timeout), 32'd0);

    do_instr(32'h002081B3, 1'b0, 0, 0, 1, mk("add_drop", ALU_ADD, 1, 0, 2'b00, 0, 1, 4, 0));
    @(negedge clk);
    #1;
    check("drop:idle", 32'(state), 32'(ST_IDLE));
    run = 1'b1;

    // Reset lands in MEM of a store that is still waiting for the port.
    op_code = 7'b0100011; func3 = 3'b010; func7 = 7'h00;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      mem_ready = (state != ST_MEM);
      if (state == ST_MEM) begin
        rst_n = 1'b0;
        hit = 1;
      end
      #1;
      if (hit) check("swrst:mem_wr", 32'({mem_wr, instr_retired, pc_wr}), 32'd0);
    end
    check("swrst:reached", 32'(hit), 32'd1);
    @(negedge clk);
    #1;
    check("swrst:idle", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;
    mem_ready = 1'b1;

    do_illegal("ill_7f",  32'h0000007F);
    do_illegal("ill_f7",  32'h402091B3);

    fc = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (state == ST_FETCH) fc++;
      if (halted) seen = 1;
    end
    check("tmo:halted",  32'(seen),        32'd1);
    check("tmo:fetches", 32'(fc),          32'd16);
    check("tmo:flag",    32'(mem_timeout), 32'd1);
    check("tmo:illegal", 32'(illegal_op),  32'd0);
    check("tmo:mem_rd",  32'(mem_rd),      32'd0);
    do_reset();

    do_instr(32'h0050B193, 1'b0, 0, 0, 0, mk("recover", ALU_SLTU, 1, 0, 2'b00, 1, 1, 4, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
